// File: rtl/deser_pkg.sv
// Shared types and constants for the FILA serial front end.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit per word).
package deser_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    WAIT_SPACE,
    PUSH,
    HOLD
  } deser_state_t;

  localparam int QUEUE_DEPTH   = 8;
  localparam int DEFAULT_WIDTH = 8;
  localparam int HOLD_CNT_W    = 4;

  // Serial bits that make up one word on the wire.
  function automatic int serial_bits(input int width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// MSB-first shift register and bit counter for deserializer_8b.
// Optional feature macro: PARITY_CHECK_EN (final serial bit is checked, not shifted).
module deser_shift_reg
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock_10KHz,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             data_in,
  output logic [WIDTH-1:0] word,
  output logic             word_done
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_ok
`endif
);

  localparam int TOTAL = serial_bits(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 2);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last    = (r_count == CNT_W'(TOTAL - 1));
  assign word_done = shift_en && w_last;

`ifdef PARITY_CHECK_EN
  // Data bits are already complete when the parity bit arrives.
  assign word      = r_shift;
  assign parity_ok = ((^r_shift) == data_in);
`else
  assign word      = {r_shift[WIDTH-2:0], data_in};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock_10KHz) begin
    if (reset || clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (shift_en) begin
      r_count <= r_count + 1'b1;
`ifdef PARITY_CHECK_EN
      if (!w_last) r_shift <= {r_shift[WIDTH-2:0], data_in};
`else
      r_shift <= {r_shift[WIDTH-2:0], data_in};
`endif
    end
  end

endmodule

// File: rtl/deserializer_8b.sv
// Serial-to-parallel front end for FILA: collects a word, waits for space, pushes once, holds.
// Optional feature macro: PARITY_CHECK_EN (even-parity check; bad words are discarded).
module deserializer_8b
  import deser_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clock_10KHz,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             queue_full_in,
  output logic [WIDTH-1:0] data_out,
  output logic             enqueue_out,
  output logic             status_out,
  output logic             parity_err_out
);

  deser_state_t          r_state;
  deser_state_t          w_next_state;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [WIDTH-1:0]      r_data_out;
  logic [WIDTH-1:0]      w_word;
  logic                  w_shift_en;
  logic                  w_clear;
  logic                  w_word_done;
  logic                  w_accept;
  logic                  w_hold_done;

  assign w_shift_en  = (r_state == COLLECT) && write_in;
  assign w_hold_done = (r_hold_cnt == HOLD_CNT_W'(HOLD_CYCLES - 1));

`ifdef PARITY_CHECK_EN
  logic w_parity_ok;
  logic r_parity_err;

  assign w_accept = w_word_done && w_parity_ok;
  // A bad word is dropped on the spot so collection restarts from bit 0.
  assign w_clear  = ((r_state == HOLD) && w_hold_done) || (w_word_done && !w_parity_ok);
`else
  assign w_accept = w_word_done;
  assign w_clear  = (r_state == HOLD) && w_hold_done;
`endif

  deser_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clock_10KHz(clock_10KHz),
    .reset      (reset),
    .shift_en   (w_shift_en),
    .clear      (w_clear),
    .data_in    (data_in),
    .word       (w_word),
    .word_done  (w_word_done)
`ifdef PARITY_CHECK_EN
    ,
    .parity_ok  (w_parity_ok)
`endif
  );

  always_ff @(posedge clock_10KHz) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of a combinational block gets a default first,
  // otherwise unlisted paths would infer latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT:    if (w_accept)       w_next_state = WAIT_SPACE;
      WAIT_SPACE: if (!queue_full_in) w_next_state = PUSH;
      PUSH:                           w_next_state = HOLD;
      HOLD:       if (w_hold_done)    w_next_state = COLLECT;
      default:                        w_next_state = COLLECT;
    endcase
  end

  always_comb begin
    enqueue_out = 1'b0;
    status_out  = 1'b0;
    case (r_state)
      COLLECT: status_out  = 1'b1;
      PUSH:    enqueue_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock_10KHz) begin
    if (reset || (r_state == PUSH)) r_hold_cnt <= '0;
    else if ((r_state == HOLD) && !w_hold_done) r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  // The word is captured on the completing edge and frozen until the next word.
  always_ff @(posedge clock_10KHz) begin
    if (reset)         r_data_out <= '0;
    else if (w_accept) r_data_out <= w_word;
  end

  assign data_out = r_data_out;

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clock_10KHz) begin
    if (reset) r_parity_err <= 1'b0;
    else       r_parity_err <= w_word_done && !w_parity_ok;
  end

  assign parity_err_out = r_parity_err;
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer_8b.sv
// Scoreboard bench for deserializer_8b with a behavioural FILA queue model.
// Optional feature macro: PARITY_CHECK_EN (adds parity-bit stimulus and error checks).
module tb_deserializer_8b;
  import deser_pkg::*;

  localparam int W    = 8;
  localparam int HOLD = 2;

  typedef struct {
    logic [W-1:0] word;
    bit           chk_lat;
    int           last_edge;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         data_in;
  logic         write_in;
  logic         queue_full_in;
  logic [W-1:0] data_out;
  logic         enqueue_out;
  logic         status_out;
  logic         parity_err_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t         sb[$];
  logic [W-1:0] fila[$];
  bit           use_fila   = 1'b0;
  bit           force_full = 1'b0;
  bit           fila_full  = 1'b0;
  int           deq_reqs   = 0;
  int           deq_done   = 0;
  logic [W-1:0] last_deq   = '0;
  int           hold_left  = 0;
  logic [W-1:0] hold_word  = '0;
  int           enq_count  = 0;
  int           err_seen   = 0;
  int           exp_err    = 0;

  assign queue_full_in = use_fila ? fila_full : force_full;

  deserializer_8b #(
    .WIDTH      (W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock_10KHz   (clk),
    .reset         (reset),
    .data_in       (data_in),
    .write_in      (write_in),
    .queue_full_in (queue_full_in),
    .data_out      (data_out),
    .enqueue_out   (enqueue_out),
    .status_out    (status_out),
    .parity_err_out(parity_err_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on every push strobe, hold-window checks, FILA model.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_left = 0;
    end else begin
      if (hold_left > 0) begin
        check("hold_no_enqueue", enqueue_out, 0);
        check("hold_data_stable", data_out, hold_word);
        check("hold_status_low", status_out, 0);
        hold_left--;
      end else if (enqueue_out) begin
        enq_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_enqueue actual=%0h required=no_push (cycle %0d)", data_out, cyc);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.word) begin
            failures++;
            $display("FAIL enqueue_data actual=%0h required=%0h (cycle %0d)", data_out, e.word, cyc);
          end
          // Strobe visible one edge after the last-bit edge, so FILA samples it two edges later.
          if (e.chk_lat) check("enqueue_latency", cyc - e.last_edge, 1);
        end
        hold_word = data_out;
        hold_left = HOLD;
        if (use_fila) fila.push_back(data_out);
      end
      if (deq_reqs > deq_done && fila.size() > 0) begin
        last_deq = fila.pop_front();
        deq_done++;
      end
      fila_full = (fila.size() >= QUEUE_DEPTH);
      if (parity_err_out) err_seen++;
    end
  end

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit corrupt,
                           input bit hold_full, input bit chk_lat);
    logic [W:0] bits;
    int         nbits;
    int         n = 0;
    exp_t       e;
    while (!status_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", n < 200, 1);
    force_full = hold_full;
`ifdef PARITY_CHECK_EN
    bits  = {w, (^w) ^ corrupt};
    nbits = W + 1;
`else
    bits  = {1'b0, w};
    nbits = W;
`endif
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      data_in  = bits[i];
      write_in = 1'b1;
      if (gap > 0 && i > 0) begin
        @(negedge clk);
        write_in = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    write_in = 1'b0;
    if (!corrupt) begin
      e.word      = w;
      e.chk_lat   = chk_lat && !hold_full;
      e.last_edge = cyc;
      sb.push_back(e);
    end else begin
      exp_err++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || hold_left != 0 || !status_out) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 200, 1);
  endtask

  initial begin
    int           base;
    int           rel;
    bit           full;
    logic [W-1:0] words[9];

    reset    = 1'b1;
    data_in  = 1'b0;
    write_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 0);
    check("reset_enqueue", enqueue_out, 0);
    check("reset_status", status_out, 1);
    check("reset_parity_err", parity_err_out, 0);
    reset = 1'b0;

    // 1: single word, minimum latency.
    base = enq_count;
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b1);
    drain();
    check("t1_data", data_out, 8'hA5);
    check("t1_enq_count", enq_count - base, 1);

    // 2: queue full while the word waits; bits offered meanwhile must be dropped.
    base = enq_count;
    send_word(8'h3C, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      data_in  = 1'($urandom);
      write_in = ~write_in;
    end
    @(negedge clk);
    write_in = 1'b0;
    check("t2_no_enq_while_full", enq_count - base, 0);
    check("t2_data_waiting", data_out, 8'h3C);
    check("t2_status_waiting", status_out, 0);
    force_full = 1'b0;
    drain();
    check("t2_one_enq", enq_count - base, 1);
    send_word(8'hC3, 0, 1'b0, 1'b0, 1'b1);
    drain();
    check("t2_next_word", data_out, 8'hC3);

    // 3: back-to-back words with 3-cycle strobe gaps.
    base = enq_count;
    send_word(8'h01, 3, 1'b0, 1'b0, 1'b1);
    send_word(8'hFF, 3, 1'b0, 1'b0, 1'b1);
    drain();
    check("t3_two_enq", enq_count - base, 2);
    check("t3_last_data", data_out, 8'hFF);

    // 4: reset after 5 bits of 8'h77, then a clean word.
    for (int i = W - 1; i >= 3; i--) begin
      @(negedge clk);
      data_in  = 1'(8'h77 >> i);
      write_in = 1'b1;
    end
    @(negedge clk);
    write_in = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("t4_rst_data", data_out, 0);
    check("t4_rst_status", status_out, 1);
    check("t4_rst_enqueue", enqueue_out, 0);
    reset = 1'b0;
    base  = enq_count;
    send_word(8'h12, 0, 1'b0, 1'b0, 1'b1);
    drain();
    check("t4_no_residue", data_out, 8'h12);
    check("t4_enq_count", enq_count - base, 1);

`ifdef PARITY_CHECK_EN
    // 5: good parity pushes; bad parity pulses the error and drops the word.
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b1);
    drain();
    check("t5_good_data", data_out, 8'hA5);
    base = enq_count;
    send_word(8'hA5, 0, 1'b1, 1'b0, 1'b0);
    check("t5_err_pulse", parity_err_out, 1);
    @(negedge clk);
    check("t5_err_one_cycle", parity_err_out, 0);
    check("t5_status_collect", status_out, 1);
    check("t5_data_kept", data_out, 8'hA5);
    repeat (5) @(negedge clk);
    check("t5_no_enq", enq_count - base, 0);
    send_word(8'h5A, 0, 1'b0, 1'b0, 1'b1);
    drain();
    check("t5_after_err", data_out, 8'h5A);
`endif

    // Randomized words, gaps and backpressure.
    for (int k = 0; k < 16; k++) begin
      full = ($urandom_range(0, 3) == 0);
      send_word(8'($urandom), int'($urandom_range(0, 2)), 1'b0, full, 1'b1);
      if (full) begin
        rel = int'($urandom_range(1, 6));
        repeat (rel) @(negedge clk);
        force_full = 1'b0;
      end
    end
    drain();

    // 6: feed the FILA model; the ninth word waits until a dequeue frees a slot.
    use_fila = 1'b1;
    base     = enq_count;
    for (int k = 0; k < 9; k++) begin
      words[k] = 8'($urandom);
      send_word(words[k], 0, 1'b0, 1'b0, k < 8);
    end
    repeat (20) @(negedge clk);
    check("t6_queue_saturated", fila.size(), QUEUE_DEPTH);
    check("t6_eight_enq", enq_count - base, 8);
    check("t6_waiting", status_out, 0);
    check("t6_word9_present", data_out, words[8]);
    deq_reqs++;
    drain();
    check("t6_dequeued_first", last_deq, words[0]);
    check("t6_nine_enq", enq_count - base, 9);
    check("t6_queue_refilled", fila.size(), QUEUE_DEPTH);
    check("t6_tail_word9", fila[fila.size() - 1], words[8]);
    use_fila = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("parity_err_pulses", err_seen, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
